// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner, in-order imem requester and instruction FIFO ahead of IF/ID.
// Optional FETCH_QUEUE_BYPASS_EN: a response reaching an empty queue is presented in the same cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [31:0]              mem_req_addr,
    input  logic                     mem_rsp_valid,
    input  logic [31:0]              mem_rsp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instruction,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic [31:0]   tag_q [DEPTH];
    logic [31:0]   tag_d [DEPTH];

    logic [CW:0]   inflight_sum;
    logic [CW-1:0] pend_cnt;
    logic          accept, rsp, dropping, keep;
    logic          fifo_empty, push, pop_fifo;

    assign fifo_empty   = (count_q == '0);
    assign inflight_sum = {1'b0, count_q} + {1'b0, outstanding_q};

    assign mem_req_valid = !reset && !redirect_valid
                         && (inflight_sum < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign accept        = mem_req_valid && mem_req_ready;

    // Responses with nothing outstanding are spurious and ignored.
    assign rsp      = mem_rsp_valid && (outstanding_q != '0);
    assign dropping = rsp && (drop_q != '0);
    assign keep     = rsp && (drop_q == '0) && !redirect_valid && !reset;
    assign pend_cnt = outstanding_q - CW'(rsp);
    assign occupancy = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass    = keep && fifo_empty;
    assign out_valid = !fifo_empty || bypass;
    assign push      = keep && !(bypass && out_ready);
    assign pop_fifo  = out_valid && out_ready && !fifo_empty;

    always_comb begin
        out_instruction = '0;
        out_pc          = '0;
        if (!fifo_empty) begin
            out_instruction = instr_q[head_q];
            out_pc          = pc_q[head_q];
        end else if (bypass) begin
            out_instruction = mem_rsp_data;
            out_pc          = tag_q[tag_rd_q];
        end
    end
`else
    assign out_valid       = !fifo_empty;
    assign push            = keep;
    assign pop_fifo        = out_valid && out_ready;
    assign out_instruction = fifo_empty ? 32'h0 : instr_q[head_q];
    assign out_pc          = fifo_empty ? 32'h0 : pc_q[head_q];
`endif

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);
        drop_d        = drop_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        tag_d         = tag_q;

        if (accept) begin
            fetch_pc_d      = fetch_pc_q + PC_STEP;
            tag_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d        = tag_wr_q + AW'(1);
        end
        if (dropping)
            drop_d = drop_q - CW'(1);
        if (keep)
            tag_rd_d = tag_rd_q + AW'(1);
        if (push) begin
            instr_d[tail_q] = mem_rsp_data;
            pc_d[tail_q]    = tag_q[tag_rd_q];
            tail_d          = tail_q + AW'(1);
        end
        if (pop_fifo)
            head_d = head_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop_fifo);

        // Everything still in flight after a redirect belongs to the wrong path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_d     = outstanding_d;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= pend_cnt;
            drop_q        <= pend_cnt;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
        end
        instr_q <= instr_d;
        pc_q    <= pc_d;
        tag_q   <= tag_d;
    end

endmodule
